prefix_add_arbiter: RTL and testbench

//  Shares one W-bit prefixAdd instance (ports a, b, cin, S) between N_REQ requesters.

---
 rtl/prefix_add_arbiter_if.sv | 42 ++++
 rtl/prefix_add_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_prefix_add_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// prefix_add_arbiter_if
//   Bundle of every signal between the prefix-add arbiter, its requesters and
//   the shared prefixAdd instance.
//
//   Requester side : req, a_in, b_in, cin_in (packed, requester i at [i*W +: W])
//                    gnt, rsp_valid (one-hot), rsp_ready, rsp_sum/cout/ovf
//   Adder side     : add_a, add_b, add_cin (registered, to prefixAdd.a/b/cin)
//                    add_s (combinational, from prefixAdd.S)
//
//   slave  : view taken by the arbiter
//   master : view taken by the surroundings (requesters + adder)
// ---------------------------------------------------------------------------
interface prefix_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   cin_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_sum;
  logic               rsp_cout;
  logic               rsp_ovf;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic               add_cin;
  logic [W-1:0]       add_s;

  modport slave (
    input  req, a_in, b_in, cin_in, rsp_ready, add_s,
    output gnt, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, add_a, add_b, add_cin
  );

  modport master (
    output req, a_in, b_in, cin_in, rsp_ready, add_s,
    input  gnt, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/prefix_add_arbiter.sv
// ---------------------------------------------------------------------------
// prefix_add_arbiter
//   Time-shares one external W-bit prefixAdd between N_REQ requesters.
//   A round-robin pointer picks the winner in IDLE; the winner's operands are
//   registered straight onto the adder inputs, the sum is captured one cycle
//   later together with the derived unsigned carry-out and signed overflow,
//   and the result is held until the shared rsp_ready handshake.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (aborts any in-flight op)
//     bus    : prefix_add_arbiter_if.slave (request/response + adder wiring)
//
//   Sequence per operation (minimum 3 cycles, never overlapped):
//     IDLE --arbitrate--> EXEC (gnt pulse) --capture--> RESP --rsp_ready--> IDLE
// ---------------------------------------------------------------------------
module prefix_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prefix_add_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_REQ_V = (IDX_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Reduce an index in [0, 2*N_REQ-2] back into [0, N_REQ-1].
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] v);
    logic [IDX_W:0] t;
    if (v >= N_REQ_V) begin
      t = v - N_REQ_V;
    end else begin
      t = v;
    end
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // The adder exposes no carry-out: recover it from the operand MSBs and the
  // sum MSB. If both MSBs are set a carry always leaves; if exactly one is set
  // the carry leaves only when the sum MSB collapsed to 0.
  function automatic logic carry_out(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
  endfunction

  // Signed overflow: like-signed operands producing a differently-signed sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [IDX_W-1:0]   own_q,       own_d;
  logic [N_REQ-1:0]   gnt_q,       gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0]       rsp_sum_q,   rsp_sum_d;
  logic               rsp_cout_q,  rsp_cout_d;
  logic               rsp_ovf_q,   rsp_ovf_d;
  logic [W-1:0]       add_a_q,     add_a_d;
  logic [W-1:0]       add_b_q,     add_b_d;
  logic               add_cin_q,   add_cin_d;

  // Arbitration result
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;

  // Round-robin search: first asserted req starting at ptr_q, wrapping.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = {IDX_W{1'b0}};
    cand_idx = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_idx = wrap_idx({1'b0, ptr_q} + (IDX_W+1)'(i));
      if (!win_vld && bus.req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end else begin
        win_vld = win_vld;
        win_idx = win_idx;
      end
    end
  end

  // State register plus all datapath flops; reset aborts any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      own_q       <= {IDX_W{1'b0}};
      gnt_q       <= {N_REQ{1'b0}};
      rsp_valid_q <= {N_REQ{1'b0}};
      rsp_sum_q   <= {W{1'b0}};
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      add_a_q     <= {W{1'b0}};
      add_b_q     <= {W{1'b0}};
      add_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
    end
  end

  // Next-state logic for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath next values per state.
  always_comb begin
    ptr_d       = ptr_q;
    own_d       = own_q;
    gnt_d       = {N_REQ{1'b0}};   // grant is a single-cycle pulse
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;       // result fields persist after handshake
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          // Operands are captured on the same edge that issues the grant, so
          // the requester may drop them as soon as it sees gnt.
          add_a_d   = bus.a_in[win_idx*W +: W];
          add_b_d   = bus.b_in[win_idx*W +: W];
          add_cin_d = bus.cin_in[win_idx];
          own_d     = win_idx;
          gnt_d     = onehot(win_idx);
          ptr_d     = wrap_idx({1'b0, win_idx} + {{IDX_W{1'b0}}, 1'b1});
        end else begin
          ptr_d = ptr_q;
        end
      end
      EXEC: begin
        rsp_sum_d   = bus.add_s;
        rsp_cout_d  = carry_out(add_a_q[W-1], add_b_q[W-1], bus.add_s[W-1]);
        rsp_ovf_d   = signed_ovf(add_a_q[W-1], add_b_q[W-1], bus.add_s[W-1]);
        rsp_valid_d = onehot(own_q);
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = {N_REQ{1'b0}};
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        rsp_valid_d = {N_REQ{1'b0}};
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;

endmodule

// File: tb/tb_prefix_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prefix_add_arbiter
//   Directed bench for prefix_add_arbiter with a behavioural prefixAdd model.
// ---------------------------------------------------------------------------
module tb_prefix_add_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  prefix_add_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  prefix_add_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External adder model
  logic [W:0] add_full;
  assign add_full  = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};
  assign bus.add_s = add_full[W-1:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
    bus.cin_in[i]      = c;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.a_in      = 32'h0;
    bus.b_in      = 32'h0;
    bus.cin_in    = 4'b0000;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.rsp_sum !== 8'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", bus.rsp_sum); end
    total++; if (bus.add_a !== 8'd0) begin bad++; $display("FAIL reset_add_a: got %0d want 0", bus.add_a); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_op(0, 8'd100, 8'd24, 1'b0);
    bus.req = 4'b0001;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
    total++; if (bus.add_a !== 8'd100) begin bad++; $display("FAIL single_add_a: got %0d want 100", bus.add_a); end
    total++; if (bus.add_b !== 8'd24) begin bad++; $display("FAIL single_add_b: got %0d want 24", bus.add_b); end
    // operands change after capture must not matter
    bus.req = 4'b0000;
    set_op(0, 8'd0, 8'd0, 1'b1);
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
    total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid); end
    total++; if (bus.rsp_sum !== 8'd124) begin bad++; $display("FAIL single_sum: got %0d want 124", bus.rsp_sum); end
    total++; if (bus.rsp_cout !== 1'b0) begin bad++; $display("FAIL single_cout: got %b want 0", bus.rsp_cout); end
    total++; if (bus.rsp_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", bus.rsp_ovf); end
    tick();
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_handshake: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.rsp_sum !== 8'd124) begin bad++; $display("FAIL single_sum_retained: got %0d want 124", bus.rsp_sum); end
  endtask

  task automatic test_arith();
    logic [7:0] va [3] = '{8'd90, 8'd200, 8'd255};
    logic [7:0] vb [3] = '{8'd60, 8'd100, 8'd0};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es [3] = '{8'd150, 8'd45, 8'd0};
    logic       eco[3] = '{1'b0, 1'b1, 1'b1};
    logic       eov[3] = '{1'b1, 1'b0, 1'b0};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_op(2, va[k], vb[k], vc[k]);
      bus.req = 4'b0100;
      tick();
      total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL arith%0d_gnt: got %b want 0100", k, bus.gnt); end
      bus.req = 4'b0000;
      tick();
      total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL arith%0d_rsp_valid: got %b want 0100", k, bus.rsp_valid); end
      total++; if (bus.rsp_sum !== es[k]) begin bad++; $display("FAIL arith%0d_sum: got %0d want %0d", k, bus.rsp_sum, es[k]); end
      total++; if (bus.rsp_cout !== eco[k]) begin bad++; $display("FAIL arith%0d_cout: got %b want %b", k, bus.rsp_cout, eco[k]); end
      total++; if (bus.rsp_ovf !== eov[k]) begin bad++; $display("FAIL arith%0d_ovf: got %b want %b", k, bus.rsp_ovf, eov[k]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_s [5] = '{8'd10, 8'd21, 8'd32, 8'd43, 8'd10};
    int n;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_op(i, 8'((i+1)*10), 8'(i), 1'b0);
    bus.rsp_ready = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (bus.gnt === 4'b0000 && n < 10);
      total++; if (bus.gnt !== exp_g[k]) begin bad++; $display("FAIL rr%0d_gnt: got %b want %b", k, bus.gnt, exp_g[k]); end
      tick();
      total++; if (bus.rsp_valid !== exp_g[k]) begin bad++; $display("FAIL rr%0d_owner: got %b want %b", k, bus.rsp_valid, exp_g[k]); end
      total++; if (bus.rsp_sum !== exp_s[k]) begin bad++; $display("FAIL rr%0d_sum: got %0d want %0d", k, bus.rsp_sum, exp_s[k]); end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_hold();
    set_op(0, 8'd1, 8'd2, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req = 4'b0001;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL hold_gnt: got %b want 0001", bus.gnt); end
    bus.req = 4'b1110;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL hold%0d_rsp_valid: got %b want 0001", k, bus.rsp_valid); end
      total++; if (bus.rsp_sum !== 8'd3) begin bad++; $display("FAIL hold%0d_sum: got %0d want 3", k, bus.rsp_sum); end
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL hold%0d_no_gnt: got %b want 0000", k, bus.gnt); end
      tick();
    end
    total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL hold_last: got %b want 0001", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL hold_release: got %b want 0000", bus.rsp_valid); end
    tick();
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL hold_next_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    bus.rsp_ready = 1'b1;
    set_op(0, 8'd7, 8'd8, 1'b0);
    set_op(3, 8'd9, 8'd9, 1'b0);
    bus.req = 4'b1000;
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL wrap_first_gnt: got %b want 1000", bus.gnt); end
    bus.req = 4'b1001;
    tick();
    total++; if (bus.rsp_valid !== 4'b1000) begin bad++; $display("FAIL wrap_first_owner: got %b want 1000", bus.rsp_valid); end
    tick();
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL wrap_gnt0: got %b want 0001", bus.gnt); end
    tick();
    total++; if (bus.rsp_sum !== 8'd15) begin bad++; $display("FAIL wrap_sum0: got %0d want 15", bus.rsp_sum); end
    tick();
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL wrap_gnt3: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_exec();
    bus.rsp_ready = 1'b1;
    set_op(0, 8'd5, 8'd6, 1'b1);
    bus.req = 4'b0001;
    tick();
    total++; if (bus.add_a !== 8'd5) begin bad++; $display("FAIL rexec_pre_add_a: got %0d want 5", bus.add_a); end
    total++; if (bus.add_cin !== 1'b1) begin bad++; $display("FAIL rexec_pre_cin: got %b want 1", bus.add_cin); end
    bus.req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rexec_gnt: got %b want 0000", bus.gnt); end
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL rexec_rsp_valid: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.add_a !== 8'd0) begin bad++; $display("FAIL rexec_add_a: got %0d want 0", bus.add_a); end
    total++; if (bus.add_b !== 8'd0) begin bad++; $display("FAIL rexec_add_b: got %0d want 0", bus.add_b); end
    total++; if (bus.add_cin !== 1'b0) begin bad++; $display("FAIL rexec_add_cin: got %b want 0", bus.add_cin); end
    #3;
    rst_n = 1'b1;
    set_op(2, 8'd20, 8'd22, 1'b0);
    bus.req = 4'b0100;
    tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL rexec_after_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    total++; if (bus.rsp_sum !== 8'd42) begin bad++; $display("FAIL rexec_after_sum: got %0d want 42", bus.rsp_sum); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_hold();
    test_wrap();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
